score_event_pulser: RTL and testbench
=====================================

# score_event_pulser

Front-end conditioning stage that sits directly upstream of each player's score digit counter. It synchronizes and debounces three raw scoring keys (hit, bonus, penalty) and arbitrates between them. It then issues mutually exclusive single-cycle `plus1` / `plus2` / `minus2` command pulses, spaced so the downstream counter and its carry/borrow chain settle between commands. One key press produces exactly one pulse, and simultaneous presses are queued rather than lost.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4, is the number of consecutive synchronized samples a key must hold a new level before it is accepted. Minimum 1.
- `GAP_CYCLES`, default 2, is the number of idle cycles forced after every emitted pulse. Minimum 0.

Ports:
- `Clock` input 1: the single system clock. All logic is on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `enable` input 1: when high, new key edges are accepted. When low, new edges are ignored but already-pending events still drain.
- `hitKey` input 1: raw, asynchronous key. A press is worth +1.
- `bonusKey` input 1: raw, asynchronous key. A press is worth +2.
- `penaltyKey` input 1: raw, asynchronous key. A press is worth -2.
- `plus1` output 1: registered one-cycle command pulse.
- `plus2` output 1: registered one-cycle command pulse.
- `minus2` output 1: registered one-cycle command pulse.
- `busy` output 1: high while any event is pending or the FSM is not in IDLE.
- `eventDropped` output 1: sticky flag, set when an accepted edge hits an already-pending slot. Cleared only by reset.

## Operation
Per-key pipeline:
- Two-flop synchronizer, then debouncer, then rising-edge detector.
- The debouncer holds a stable level `deb` (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - While the synchronized value equals `deb`, the counter is cleared.
  - While it differs, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, `deb` takes the new value and the counter clears.
- A `deb` 0→1 transition while `enable`=1 is an accepted edge. Release (1→0) generates nothing.

Pending flags:
- There is one pending flag per key: pendHit, pendBonus, pendPen.
- An accepted edge sets its flag on the same clock edge that `deb` rises.
- If that flag is already set, or is being cleared by the arbiter on that same edge, the new event is discarded and `eventDropped` is set.

FSM states: IDLE, EMIT, GAP.
- **IDLE**: if any flag is set, go to EMIT on the next edge. On that edge the highest-priority flag is cleared and its output register is set. Priority is bonus (`plus2`) > hit (`plus1`) > penalty (`minus2`).
- **EMIT**: exactly one output is high for this one cycle.
  - Go to GAP on the next edge if GAP_CYCLES>0.
  - Otherwise go back through the IDLE decision: if a flag is pending, emit back-to-back from EMIT; if not, go to IDLE.
- **GAP**: outputs are 0 and the gap counter counts GAP_CYCLES cycles, then goes to IDLE. Flags may still be set during GAP.

Invariants:
- At most one of `plus1`/`plus2`/`minus2` is high in any cycle.
- Each accepted edge produces exactly one pulse unless it is dropped.

`busy` = (state≠IDLE) | any pending flag. It is combinational from registers.

## Timing
- Reset (asynchronous, while `Reset`=0):
  - all outputs are 0;
  - synchronizers, `deb`, counters, flags and `eventDropped` are cleared;
  - the FSM is in IDLE.
- Reset asserted mid-EMIT or mid-GAP aborts immediately: the pulse is cut, and pending events are lost and not emitted.
- Latency: a key is first sampled high at edge E0 and held. Then:
  - the synchronizer output is valid at E1;
  - `deb` rises and the flag is set at E(1+DEBOUNCE_CYCLES);
  - the pulse register is set at E(2+DEBOUNCE_CYCLES) and is high for that one cycle only, given the FSM was IDLE.
- Spacing: consecutive pulses are separated by exactly GAP_CYCLES low cycles when events are backlogged.
- A key held indefinitely produces one pulse. A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces none.
- Simultaneous accepted edges on several keys in the same cycle each set their flags and drain in priority order.
- An `enable` drop does not cancel pending or in-flight pulses. An edge whose `deb` rises while `enable`=0 is lost permanently; it is not replayed when `enable` returns.

## Test plan
- **Reset:** hold `Reset`=0 with keys toggling → all outputs 0 and `busy`=0. Release reset → no spurious pulse.
- **Single press** (D=4, G=2): `hitKey` high from E0 → `plus1` high only in the cycle after E6, and `busy` goes low at E9.
- **Bounce rejection:** `bonusKey` high 3 cycles, low 2, high 3 (D=4) → no pulse. Then hold it high 4 or more cycles → one `plus2`.
- **Simultaneous press:** all three keys rise in the same cycle → order is `plus2`, `plus1`, `minus2`, each followed by 2 idle cycles, with no overlap.
- **Drop and sticky flag:** while `plus2` is backlogged, `hitKey` is pressed, released and pressed again before `plus1` is emitted → one `plus1` only, and `eventDropped`=1 until reset.
- **Mid-operation reset:** assert `Reset`=0 during GAP with `penaltyKey` pending → outputs 0 immediately, no `minus2` after release, and `eventDropped`=0.

Source files
------------

// File: rtl/score_event_pulser.sv
// Conditions three raw score keys (sync, debounce, edge-detect) into spaced, mutually exclusive plus1/plus2/minus2 pulses.
// Pulse leaves DEBOUNCE_CYCLES+2 edges after the key is first sampled; no backpressure, a re-press on a pending slot is dropped.
module score_event_pulser #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic enable,
  input  logic hitKey,
  input  logic bonusKey,
  input  logic penaltyKey,
  output logic plus1,
  output logic plus2,
  output logic minus2,
  output logic busy,
  output logic eventDropped
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Key lanes: bit 0 hit, bit 1 bonus, bit 2 penalty.
  localparam int K_HIT = 0;
  localparam int K_BON = 1;
  localparam int K_PEN = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [2:0]          key_raw;
  logic [2:0]          sync1_q, sync2_q;
  logic [2:0]          deb_q, deb_d;
  logic [2:0][DW-1:0]  cnt_q, cnt_d;
  logic [2:0]          accept;
  logic [2:0]          pend_q, pend_d;
  logic [2:0]          clr;
  logic                drop_q, drop_d;
  state_t              state_q, state_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                p1_q, p1_d, p2_q, p2_d, m2_q, m2_d;
  logic                decide;

  assign key_raw = {penaltyKey, bonusKey, hitKey};

  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int k = 0; k < 3; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DEB_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + DW'(1);
        end
      end
    end
  end

  assign accept = deb_d & ~deb_q & {3{enable}};

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    clr     = '0;
    p1_d    = 1'b0;
    p2_d    = 1'b0;
    m2_d    = 1'b0;
    decide  = 1'b0;
    case (state_q)
      IDLE: decide = 1'b1;
      EMIT: begin
        if (GAP_CYCLES > 0) begin
          state_d = GAP;
          gap_d   = '0;
        end else begin
          decide = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          decide = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // The end of a gap re-enters the idle decision directly so backlogged pulses are exactly GAP_CYCLES apart.
    if (decide) begin
      if (pend_q[K_BON]) begin
        clr[K_BON] = 1'b1;
        p2_d       = 1'b1;
        state_d    = EMIT;
      end else if (pend_q[K_HIT]) begin
        clr[K_HIT] = 1'b1;
        p1_d       = 1'b1;
        state_d    = EMIT;
      end else if (pend_q[K_PEN]) begin
        clr[K_PEN] = 1'b1;
        m2_d       = 1'b1;
        state_d    = EMIT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // An edge landing on a set flag is lost even if the arbiter clears that flag on the same edge.
  assign pend_d = (pend_q & ~clr) | (accept & ~pend_q);
  assign drop_d = drop_q | (|(accept & pend_q));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      state_q <= IDLE;
      gap_q   <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      m2_q    <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      gap_q   <= gap_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      m2_q    <= m2_d;
    end
  end

  assign plus1        = p1_q;
  assign plus2        = p2_q;
  assign minus2       = m2_q;
  assign busy         = (state_q != IDLE) | (|pend_q);
  assign eventDropped = drop_q;

endmodule

// File: tb/tb_score_event_pulser.sv
// Bench for score_event_pulser: instance A (D=4,G=2) and B (D=1,G=12) checked every cycle
// against an event-level model, plus a per-cycle vector table and directed corner sequences.
module tb_score_event_pulser;

  localparam int DA = 4;
  localparam int GA = 2;
  localparam int DB = 1;
  localparam int GB = 12;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic a_en = 1'b1, a_hit = 1'b0, a_bon = 1'b0, a_pen = 1'b0;
  logic b_en = 1'b1, b_hit = 1'b0, b_bon = 1'b0, b_pen = 1'b0;
  logic a_p1, a_p2, a_m2, a_busy, a_drop;
  logic b_p1, b_p2, b_m2, b_busy, b_drop;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  score_event_pulser #(.DEBOUNCE_CYCLES(DA), .GAP_CYCLES(GA)) dut_a (
    .Clock(Clock), .Reset(Reset), .enable(a_en),
    .hitKey(a_hit), .bonusKey(a_bon), .penaltyKey(a_pen),
    .plus1(a_p1), .plus2(a_p2), .minus2(a_m2), .busy(a_busy), .eventDropped(a_drop)
  );

  score_event_pulser #(.DEBOUNCE_CYCLES(DB), .GAP_CYCLES(GB)) dut_b (
    .Clock(Clock), .Reset(Reset), .enable(b_en),
    .hitKey(b_hit), .bonusKey(b_bon), .penaltyKey(b_pen),
    .plus1(b_p1), .plus2(b_p2), .minus2(b_m2), .busy(b_busy), .eventDropped(b_drop)
  );

  logic [4:0] dut_v [2];
  assign dut_v[0] = {a_p1, a_p2, a_m2, a_busy, a_drop};
  assign dut_v[1] = {b_p1, b_p2, b_m2, b_busy, b_drop};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  // Key index 0 hit, 1 bonus, 2 penalty. A level change is accepted once the last D
  // synchronized samples all disagree with the held level. The emitter is free again
  // G+1 edges after a pulse; at a free edge the best pending key is emitted.
  bit m_s1   [2][3];
  bit m_s2   [2][3];
  bit m_deb  [2][3];
  bit m_pend [2][3];
  bit m_p    [2][3];
  bit m_hist [2][3][16];
  bit m_drop [2];
  int m_n    [2];
  int m_last [2];
  int m_ready[2];

  function automatic int dp(int i); return (i == 0) ? DA : DB; endfunction
  function automatic int gp(int i); return (i == 0) ? GA : GB; endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        m_s1[i][k] = 0; m_s2[i][k] = 0; m_deb[i][k] = 0; m_pend[i][k] = 0; m_p[i][k] = 0;
        for (int j = 0; j < 16; j++) m_hist[i][k][j] = 0;
      end
      m_drop[i] = 0; m_n[i] = 0; m_last[i] = -1000; m_ready[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit [2:0] raw, input bit en);
    bit rise [3];
    bit pre  [3];
    bit clr  [3];
    bit all_diff;
    bit acc;
    int order [3] = '{1, 0, 2};
    m_n[i]++;
    for (int k = 0; k < 3; k++) begin
      for (int j = 15; j > 0; j--) m_hist[i][k][j] = m_hist[i][k][j-1];
      m_hist[i][k][0] = m_s2[i][k];
      all_diff = 1;
      for (int j = 0; j < dp(i); j++) if (m_hist[i][k][j] == m_deb[i][k]) all_diff = 0;
      rise[k] = 0;
      if (all_diff) begin
        m_deb[i][k] = ~m_deb[i][k];
        rise[k] = m_deb[i][k];
      end
      m_s2[i][k] = m_s1[i][k];
      m_s1[i][k] = raw[k];
      pre[k] = m_pend[i][k];
      clr[k] = 0;
      m_p[i][k] = 0;
    end
    if (m_n[i] >= m_ready[i] && (pre[0] || pre[1] || pre[2])) begin
      for (int o = 0; o < 3; o++) begin
        if (pre[order[o]] && !(clr[0] || clr[1] || clr[2])) begin
          clr[order[o]] = 1;
          m_p[i][order[o]] = 1;
        end
      end
      m_last[i] = m_n[i];
      m_ready[i] = m_n[i] + 1 + gp(i);
    end
    for (int k = 0; k < 3; k++) begin
      acc = rise[k] & en;
      if (acc && pre[k]) m_drop[i] = 1;
      m_pend[i][k] = (pre[k] & ~clr[k]) | (acc & ~pre[k]);
    end
  endtask

  function automatic logic [4:0] mdl_v(int i);
    logic bz;
    bz = (m_n[i] <= m_last[i] + gp(i)) || m_pend[i][0] || m_pend[i][1] || m_pend[i][2];
    return {m_p[i][0], m_p[i][1], m_p[i][2], bz, m_drop[i]};
  endfunction

  initial model_reset();

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) model_reset();
    else begin
      model_step(0, {a_pen, a_bon, a_hit}, a_en);
      model_step(1, {b_pen, b_bon, b_hit}, b_en);
    end
  end

  // ---------------- per-cycle monitors ----------------
  int cyc = 0;
  int cnt_a [3];
  int cnt_b [3];
  int overlap = 0;
  int seq_code [$];
  int seq_cyc  [$];

  initial for (int k = 0; k < 3; k++) begin cnt_a[k] = 0; cnt_b[k] = 0; end

  always @(negedge Clock) begin
    cyc++;
    for (int i = 0; i < 2; i++) chk($sformatf("model_inst%0d_cyc%0d", i, cyc), 32'(dut_v[i]), 32'(mdl_v(i)));
    cnt_a[0] += int'(a_p1); cnt_a[1] += int'(a_p2); cnt_a[2] += int'(a_m2);
    cnt_b[0] += int'(b_p1); cnt_b[1] += int'(b_p2); cnt_b[2] += int'(b_m2);
    if (int'(a_p1) + int'(a_p2) + int'(a_m2) > 1) overlap++;
    if (int'(b_p1) + int'(b_p2) + int'(b_m2) > 1) overlap++;
    if (a_p1 || a_p2 || a_m2) begin
      seq_code.push_back(a_p2 ? 2 : (a_p1 ? 1 : 3));
      seq_cyc.push_back(cyc);
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst_n;
    logic       en;
    logic       hit;
    logic       bon;
    logic       pen;
    logic [4:0] exp;   // {plus1, plus2, minus2, busy, eventDropped}
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic h, logic b, logic p, logic [4:0] x);
    vec_t v;
    v.rst_n = r; v.en = e; v.hit = h; v.bon = b; v.pen = p; v.exp = x;
    return v;
  endfunction

  vec_t tbl [14];
  int   c0, c1, c2, idx;
  bit   found;

  initial begin
    // Single hit press on A: row j drives the inputs for edge E(j-1).
    tbl[0] = mk(0, 1, 1, 0, 1, 5'b00000);
    for (int r = 1; r < 14; r++) tbl[r] = mk(1, 1, 1, 0, 0, 5'b00000);
    tbl[6].exp = 5'b00010;
    tbl[7].exp = 5'b10010;
    tbl[8].exp = 5'b00010;
    tbl[9].exp = 5'b00010;

    #1 Reset = 1'b0;
    repeat (6) begin
      {a_hit, a_bon, a_pen} = 3'($urandom_range(0, 7));
      {b_hit, b_bon, b_pen} = 3'($urandom_range(0, 7));
      @(negedge Clock);
      chk("reset_quiet_a", 32'({a_p1, a_p2, a_m2, a_busy, a_drop}), 32'd0);
      chk("reset_quiet_b", 32'({b_p1, b_p2, b_m2, b_busy, b_drop}), 32'd0);
    end
    {b_hit, b_bon, b_pen} = 3'b000;

    for (int r = 0; r < 14; r++) begin
      Reset = tbl[r].rst_n;
      a_en  = tbl[r].en;
      a_hit = tbl[r].hit;
      a_bon = tbl[r].bon;
      a_pen = tbl[r].pen;
      @(negedge Clock);
      chk($sformatf("vec_row%0d", r), 32'(dut_v[0]), 32'(tbl[r].exp));
    end
    chk("reset_no_spurious_b", 32'(cnt_b[0] + cnt_b[1] + cnt_b[2]), 32'd0);

    // Release of a held key produces nothing.
    a_hit = 1'b0;
    repeat (10) @(negedge Clock);
    chk("release_silent", 32'(cnt_a[0]), 32'd1);

    // Bounce rejection, then a long hold gives a single plus2.
    c0 = cnt_a[1];
    a_bon = 1'b1; repeat (3) @(negedge Clock);
    a_bon = 1'b0; repeat (2) @(negedge Clock);
    a_bon = 1'b1; repeat (3) @(negedge Clock);
    a_bon = 1'b0; repeat (10) @(negedge Clock);
    chk("bounce_none", 32'(cnt_a[1]), 32'(c0));
    a_bon = 1'b1; repeat (6) @(negedge Clock);
    a_bon = 1'b0; repeat (12) @(negedge Clock);
    chk("bounce_hold_one", 32'(cnt_a[1]), 32'(c0 + 1));

    // Simultaneous press drains bonus, hit, penalty with GA idle cycles between.
    seq_code.delete(); seq_cyc.delete();
    {a_hit, a_bon, a_pen} = 3'b111;
    repeat (25) @(negedge Clock);
    {a_hit, a_bon, a_pen} = 3'b000;
    repeat (10) @(negedge Clock);
    chk("simul_count", 32'(seq_code.size()), 32'd3);
    if (seq_code.size() == 3) begin
      chk("simul_order", 32'(seq_code[0] * 100 + seq_code[1] * 10 + seq_code[2]), 32'd213);
      chk("simul_gap1", 32'(seq_cyc[1] - seq_cyc[0]), 32'(GA + 1));
      chk("simul_gap2", 32'(seq_cyc[2] - seq_cyc[1]), 32'(GA + 1));
    end

    // Drop on B: hit pressed, released, re-pressed while its first event waits out the gap.
    c1 = cnt_b[0];
    b_bon = 1'b1;
    found = 0;
    for (int t = 0; t < 12 && !found; t++) begin
      @(negedge Clock);
      if (b_p2) found = 1;
    end
    chk("drop_plus2_seen", 32'(found), 32'd1);
    b_bon = 1'b0;
    b_hit = 1'b1; repeat (3) @(negedge Clock);
    b_hit = 1'b0; repeat (3) @(negedge Clock);
    b_hit = 1'b1; repeat (3) @(negedge Clock);
    b_hit = 1'b0; repeat (25) @(negedge Clock);
    chk("drop_one_plus1", 32'(cnt_b[0]), 32'(c1 + 1));
    chk("drop_flag_set", 32'(b_drop), 32'd1);
    repeat (10) @(negedge Clock);
    chk("drop_flag_sticky", 32'(b_drop), 32'd1);

    // Mid-GAP reset on A with penalty pending.
    {a_bon, a_pen} = 2'b11;
    found = 0;
    for (int t = 0; t < 15 && !found; t++) begin
      @(negedge Clock);
      if (a_p2) found = 1;
    end
    chk("rst_plus2_seen", 32'(found), 32'd1);
    @(negedge Clock);
    chk("rst_gap_busy", 32'(a_busy), 32'd1);
    {a_bon, a_pen} = 2'b00;
    c2 = cnt_a[2];
    #2 Reset = 1'b0;
    #1;
    chk("rst_immediate_a", 32'({a_p1, a_p2, a_m2, a_busy, a_drop}), 32'd0);
    chk("rst_clears_drop_b", 32'(b_drop), 32'd0);
    @(negedge Clock); @(negedge Clock);
    Reset = 1'b1;
    repeat (20) @(negedge Clock);
    chk("rst_no_minus2", 32'(cnt_a[2]), 32'(c2));
    chk("rst_drop_clear_a", 32'(a_drop), 32'd0);

    // Randomized phase; the per-cycle model comparison does the checking.
    begin
      bit lvl  [2][3];
      int hold [2][3];
      for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) begin lvl[i][k] = 0; hold[i][k] = 0; end
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < 2; i++) begin
          for (int k = 0; k < 3; k++) begin
            if (hold[i][k] == 0) begin
              lvl[i][k]  = 1'($urandom_range(0, 1));
              hold[i][k] = $urandom_range(1, 8);
            end else begin
              hold[i][k]--;
            end
          end
        end
        {a_hit, a_bon, a_pen} = {lvl[0][0], lvl[0][1], lvl[0][2]};
        {b_hit, b_bon, b_pen} = {lvl[1][0], lvl[1][1], lvl[1][2]};
        if ($urandom_range(0, 29) == 0) a_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 29) == 0) b_en = ($urandom_range(0, 3) != 0);
        if (c == 802) Reset = 1'b1;
        if (c == 800) #2 Reset = 1'b0;
        @(negedge Clock);
      end
    end

    {a_hit, a_bon, a_pen} = 3'b000;
    {b_hit, b_bon, b_pen} = 3'b000;
    a_en = 1'b1; b_en = 1'b1;
    repeat (60) @(negedge Clock);
    chk("drain_idle_a", 32'(a_busy), 32'd0);
    chk("drain_idle_b", 32'(b_busy), 32'd0);
    chk("no_overlap", 32'(overlap), 32'd0);
    idx = checks;
    $display("Result: errors=%0d of %0d checks", errors, idx);
    $finish;
  end

endmodule
